// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES cipher controller.
//   aes_mode_e  - key-size mode encoding as seen on the mode port
//   aes_state_e - controller FSM states
//   LAST_RD_*   - final round number per key size
//   last_round  - maps a mode to its final round (11 behaves as 256)
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128  = 2'b00,
        MODE_192  = 2'b01,
        MODE_256  = 2'b10,
        MODE_256X = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } aes_state_e;

    localparam logic [3:0] LAST_RD_128 = 4'd10;
    localparam logic [3:0] LAST_RD_192 = 4'd12;
    localparam logic [3:0] LAST_RD_256 = 4'd14;

    function automatic logic [3:0] last_round(input aes_mode_e mode);
        case (mode)
            MODE_128: return LAST_RD_128;
            MODE_192: return LAST_RD_192;
            default:  return LAST_RD_256;
        endcase
    endfunction

endpackage

// File: rtl/aes_rounddata.sv
// aes_rounddata: one combinational AES encryption round.
//   state_i  - current 128-bit state (byte 0 in bits [127:120], column-major)
//   rk_i     - round key for round_i
//   mode_i   - key-size mode, selects which round is the final one
//   round_i  - round number: 0 = initial AddRoundKey only,
//              last = SubBytes/ShiftRows/AddRoundKey (no MixColumns),
//              otherwise the full round
//   state_o  - next state
module aes_rounddata
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  aes_mode_e    mode_i,
    input  logic [3:0]   round_i,
    output logic [127:0] state_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: multiplicative inverse as
    // x^254 (bits 1..7 of the exponent set, bit 0 clear; 0 maps to 0),
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] sr_w;
    logic [127:0] mc_w;

    // SubBytes then ShiftRows: row r of column c comes from column (c+r)%4.
    always_comb begin
        for (int i = 0; i < 16; i++) sb[i] = sbox(state_i[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                      ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        sr_w = '0;
        mc_w = '0;
        for (int i = 0; i < 16; i++) begin
            sr_w[127-8*i -: 8] = sr[i];
            mc_w[127-8*i -: 8] = mc[i];
        end
        if (round_i == 4'd0)
            state_o = state_i ^ rk_i;
        else if (round_i == last_round(mode_i))
            state_o = sr_w ^ rk_i;
        else
            state_o = mc_w ^ rk_i;
    end

endmodule

// File: rtl/aes_cipher_ctrl.sv
// aes_cipher_ctrl: iterative AES encryption controller, one round per cycle.
// Round keys come from an external key store addressed by rk_idx.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - plaintext handshake; mode/plaintext sampled on accept
//   rk_idx, rk, rk_valid - key store read port; rk_valid=0 stalls the round
//   rd_round             - round number fed to the round datapath
//   out_valid/out_ready  - ciphertext handshake; ciphertext held while valid
//   busy                 - high while a block is in RUN or DONE
module aes_cipher_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [127:0] plaintext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    input  logic         rk_valid,
    output logic [3:0]   rd_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   round_q, round_d;
    aes_mode_e    mode_q, mode_d;
    logic [127:0] rd_out;

    aes_rounddata u_rounddata (
        .state_i (state_q),
        .rk_i    (rk),
        .mode_i  (mode_q),
        .round_i (round_q),
        .state_o (rd_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        ct_d    = ct_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = plaintext;
                    mode_d  = aes_mode_e'(mode);
                    round_d = 4'd0;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rk_valid) begin
                    state_d = rd_out;
                    // Final round: capture result, leave round_q at the last
                    // round so it never exceeds 14.
                    if (round_q == last_round(mode_q)) begin
                        ct_d  = rd_out;
                        fsm_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                // Returning to IDLE here means in_ready only rises next
                // cycle, so no accept can coincide with the output handshake.
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            ct_q    <= '0;
            round_q <= '0;
            mode_q  <= MODE_128;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready   = (fsm_q == ST_IDLE);
    assign out_valid  = (fsm_q == ST_DONE);
    assign busy       = (fsm_q != ST_IDLE);
    assign ciphertext = ct_q;
    assign rk_idx     = round_q;
    assign rd_round   = round_q;

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
module tb_aes_cipher_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [127:0] plaintext;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         rk_valid = 1'b1;
    logic [3:0]   rd_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    aes_cipher_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .plaintext  (plaintext),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .rk_valid   (rk_valid),
        .rd_round   (rd_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int checks = 0;
    int errors = 0;

    // Key store model: FIPS-197 key schedule with key bytes 00,01,02,...
    logic [7:0]   sbox_t [256];
    logic [127:0] rk_tab [16];
    always_comb rk = rk_tab[rk_idx];

    // rk_valid generator: when stall_en, drop rk_valid for 3 cycles on
    // rounds 0, 7 and 14 of the block in flight.
    bit stall_en = 1'b0;
    int scnt [16];
    always @(negedge clk) begin
        if (!busy) begin
            for (int i = 0; i < 16; i++) scnt[i] = 0;
            rk_valid = 1'b1;
        end else if (stall_en && !out_valid &&
                     (rk_idx == 4'd0 || rk_idx == 4'd7 || rk_idx == 4'd14) &&
                     scnt[rk_idx] < 3) begin
            rk_valid = 1'b0;
            scnt[rk_idx]++;
        end else begin
            rk_valid = 1'b1;
        end
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        logic [7:0] yb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            xb  = 8'(x);
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (gm(xb, yb) == 8'h01) inv = yb;
            end
            sbox_t[x] = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
                      ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic expand(input logic [1:0] m);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Offer a block at a negedge; returns #1 after the accept edge with the
    // inputs scrambled so late changes would corrupt the block if sampled.
    task automatic start_block(input string nm, input logic [1:0] m, input logic [127:0] pt);
        @(negedge clk);
        expand(m);
        mode      = m;
        plaintext = pt;
        in_valid  = 1'b1;
        chkb({nm, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        mode      = ~m;
        plaintext = ~pt;
    endtask

    // Count edges after the accept edge until out_valid; bounded.
    task automatic wait_out(input string nm, input int exp_lat);
        int cyc = 0;
        while (cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
        end
        chki({nm, "_latency"}, cyc, exp_lat);
    endtask

    typedef struct {
        string        name;
        logic [1:0]   mode;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
        bit           stall;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"aes128",      2'b00, PT, CT128, 11, 1'b0};
        vecs[1] = '{"aes192",      2'b01, PT, CT192, 13, 1'b0};
        vecs[2] = '{"aes256",      2'b10, PT, CT256, 15, 1'b0};
        vecs[3] = '{"mode11",      2'b11, PT, CT256, 15, 1'b0};
        vecs[4] = '{"aes256_stall", 2'b10, PT, CT256, 24, 1'b1};

        build_sbox();
        expand(2'b00);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'b00;
        plaintext = '0;

        repeat (2) @(posedge clk);
        #1;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chk("rst_ciphertext", ciphertext, '0);
        chki("rst_rk_idx", int'(rk_idx), 0);
        chki("rst_rd_round", int'(rd_round), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            stall_en = vecs[v].stall;
            start_block(vecs[v].name, vecs[v].mode, vecs[v].pt);
            chkb({vecs[v].name, "_busy"}, busy, 1'b1);
            wait_out(vecs[v].name, vecs[v].lat);
            chk({vecs[v].name, "_ct"}, ciphertext, vecs[v].ct);
            @(posedge clk);
            #1;
            chkb({vecs[v].name, "_ov_clear"}, out_valid, 1'b0);
            chkb({vecs[v].name, "_idle"}, in_ready, 1'b1);
            stall_en = 1'b0;
        end

        // Output backpressure, then a second block waiting on in_valid.
        @(negedge clk);
        out_ready = 1'b0;
        start_block("hold", 2'b10, PT);
        wait_out("hold", 15);
        chk("hold_ct0", ciphertext, CT256);
        @(negedge clk);
        expand(2'b00);
        mode      = 2'b00;
        plaintext = PT;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chkb("hold_ov", out_valid, 1'b1);
            chk("hold_ct", ciphertext, CT256);
            chkb("hold_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chkb("hs_ov_clear", out_valid, 1'b0);
        chkb("hs_no_accept", busy, 1'b0);
        @(posedge clk);
        #1;
        chkb("b2b_accept", busy, 1'b1);
        in_valid  = 1'b0;
        mode      = 2'b11;
        plaintext = '0;
        wait_out("b2b", 11);
        chk("b2b_ct", ciphertext, CT128);
        @(posedge clk);
        #1;

        // Reset in the middle of a block.
        start_block("rstmid", 2'b00, ~PT);
        repeat (5) @(posedge clk);
        #1;
        chki("rstmid_round", int'(rd_round), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkb("rstmid_in_ready", in_ready, 1'b1);
        chkb("rstmid_out_valid", out_valid, 1'b0);
        chkb("rstmid_busy", busy, 1'b0);
        chk("rstmid_ct", ciphertext, '0);
        chki("rstmid_rk_idx", int'(rk_idx), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chkb("rstmid_no_out", out_valid, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expand(2'b00);
        mode      = 2'b00;
        plaintext = PT;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chkb("postrst_accept", busy, 1'b1);
        in_valid  = 1'b0;
        mode      = 2'b01;
        plaintext = '0;
        wait_out("postrst", 11);
        chk("postrst_ct", ciphertext, CT128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
